// File: rtl/sdram_stream_reader.sv
// Streams a contiguous block of 16-bit words from the SDRAM bridge into a
// first-word-fall-through FIFO feeding a valid/ready consumer.
`timescale 1ns/1ps

module sdram_stream_reader #(
  parameter int unsigned ADDR_W         = 26,
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] word_count,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] bus_address,
  output logic [1:0]        bus_byte_enable,
  output logic              bus_read,
  output logic              bus_write,
  output logic [15:0]       bus_write_data,
  input  logic              bus_acknowledge,
  input  logic [15:0]       bus_read_data,
  output logic [15:0]       out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned TMR_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned TMR_W   = (TMR_RAW < 10) ? 10 : TMR_RAW;

  typedef enum logic [1:0] {IDLE, ISSUE, GAP, DRAIN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] remaining;
  logic [TMR_W-1:0]  timer;
  logic              abort_pending;

  logic [15:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;

  logic              pop_c;
  logic              ack_c;
  logic              timeout_c;
  logic              cancel_c;
  logic              push_c;
  logic              flush_c;
  logic              fifo_full_c;
  logic [PTR_W-1:0]  rd_next_c;
  logic [CNT_W-1:0]  count_next_c;

  assign bus_byte_enable = 2'b11;
  assign bus_write       = 1'b0;
  assign bus_write_data  = 16'h0000;

  // Handshake decode shared by the FSM and the FIFO.
  always_comb begin
    pop_c        = out_valid & out_ready;
    ack_c        = (state == ISSUE) & bus_acknowledge;
    timeout_c    = (state == ISSUE) & ~bus_acknowledge &
                   (timer == TMR_W'(TIMEOUT_CYCLES - 1));
    cancel_c     = abort | abort_pending;
    push_c       = ack_c & ~cancel_c;
    flush_c      = timeout_c | (ack_c & cancel_c) |
                   (((state == GAP) | (state == DRAIN)) & abort);
    fifo_full_c  = (count == CNT_W'(FIFO_DEPTH));
    rd_next_c    = rd_ptr + PTR_W'(pop_c);
    count_next_c = count + CNT_W'(push_c) - CNT_W'(pop_c);
  end

  // Transfer control: one outstanding read, gated on FIFO space.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      bus_read      <= 1'b0;
      bus_address   <= '0;
      remaining     <= '0;
      timer         <= '0;
      abort_pending <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (word_count == '0) begin
              done <= 1'b1;
            end else begin
              state         <= ISSUE;
              busy          <= 1'b1;
              bus_read      <= 1'b1;
              bus_address   <= start_addr & ~ADDR_W'(1);
              remaining     <= word_count;
              timer         <= '0;
              abort_pending <= 1'b0;
            end
          end
        end
        ISSUE: begin
          // The bridge cannot withdraw a read, so abort waits for ack or timeout.
          if (bus_acknowledge) begin
            bus_read <= 1'b0;
            timer    <= '0;
            if (cancel_c) begin
              state         <= IDLE;
              busy          <= 1'b0;
              abort_pending <= 1'b0;
            end else begin
              bus_address <= bus_address + ADDR_W'(2);
              remaining   <= remaining - ADDR_W'(1);
              state       <= (remaining == ADDR_W'(1)) ? DRAIN : GAP;
            end
          end else if (timeout_c) begin
            bus_read      <= 1'b0;
            error         <= 1'b1;
            timer         <= '0;
            state         <= IDLE;
            busy          <= 1'b0;
            abort_pending <= 1'b0;
          end else begin
            timer <= timer + TMR_W'(1);
            if (abort) abort_pending <= 1'b1;
          end
        end
        GAP: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (!fifo_full_c) begin
            state    <= ISSUE;
            bus_read <= 1'b1;
            timer    <= '0;
          end
        end
        DRAIN: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if ((count == '0) || ((count == CNT_W'(1)) && pop_c)) begin
            done  <= 1'b1;
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_clk) begin
    if (push_c) mem[wr_ptr] <= bus_read_data;
  end

  // FWFT head register: a push into an empty slot at the new read pointer bypasses the array.
  always_ff @(posedge clk_clk) begin
    if (reset_reset || flush_c) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= 16'h0000;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr    <= rd_next_c;
      count     <= count_next_c;
      out_valid <= (count_next_c != '0);
      if (push_c && (wr_ptr == rd_next_c)) out_data <= bus_read_data;
      else                                 out_data <= mem[rd_next_c];
    end
  end

endmodule

// File: tb/tb_sdram_stream_reader.sv
// Directed bench for sdram_stream_reader with a simple bridge responder.
`timescale 1ns/1ps

module tb_sdram_stream_reader;

  localparam int unsigned ADDR_W = 26;

  logic              clk_clk = 1'b0;
  logic              reset_reset;
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] word_count;
  logic              abort;
  logic              busy;
  logic              done;
  logic              error;
  logic [ADDR_W-1:0] bus_address;
  logic [1:0]        bus_byte_enable;
  logic              bus_read;
  logic              bus_write;
  logic [15:0]       bus_write_data;
  logic              bus_acknowledge;
  logic [15:0]       bus_read_data;
  logic [15:0]       out_data;
  logic              out_valid;
  logic              out_ready;

  always #5 clk_clk = ~clk_clk;

  sdram_stream_reader #(
    .ADDR_W(ADDR_W), .FIFO_DEPTH(16), .TIMEOUT_CYCLES(1024)
  ) dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset), .start(start),
    .start_addr(start_addr), .word_count(word_count), .abort(abort),
    .busy(busy), .done(done), .error(error), .bus_address(bus_address),
    .bus_byte_enable(bus_byte_enable), .bus_read(bus_read),
    .bus_write(bus_write), .bus_write_data(bus_write_data),
    .bus_acknowledge(bus_acknowledge), .bus_read_data(bus_read_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [15:0] data_for(input logic [ADDR_W-1:0] a);
    return a[16:1] ^ 16'h5A00;
  endfunction

  // Bridge responder: acks ack_delay cycles after bus_read rises.
  bit bridge_on = 1'b1;
  int ack_delay = 3;
  int seen      = 0;
  always @(posedge clk_clk) begin
    #1;
    if (bus_acknowledge) begin
      bus_acknowledge = 1'b0;
      seen = 0;
    end else if (bus_read === 1'b1 && bridge_on) begin
      seen++;
      if (seen > ack_delay) begin
        bus_acknowledge = 1'b1;
        bus_read_data   = data_for(bus_address);
        seen = 0;
      end
    end else begin
      seen = 0;
    end
  end

  // Passive monitor sampled mid-cycle.
  int reads_issued = 0, done_cnt = 0, error_cnt = 0, busy_cyc = 0, b2b_err = 0;
  int run = 0, last_run = 0;
  logic prev_read = 1'b0, prev_take = 1'b0;
  logic [ADDR_W-1:0] addr_q[$];
  logic [15:0]       data_q[$];
  always @(negedge clk_clk) begin
    if (bus_read === 1'b1 && !prev_read) begin
      reads_issued++;
      addr_q.push_back(bus_address);
    end
    if (bus_read === 1'b1 && prev_take) b2b_err++;
    if (out_valid === 1'b1 && out_ready === 1'b1) data_q.push_back(out_data);
    if (done === 1'b1) done_cnt++;
    if (error === 1'b1) error_cnt++;
    if (busy === 1'b1) busy_cyc++;
    if (bus_read === 1'b1) run++;
    else if (run != 0) begin
      last_run = run;
      run = 0;
    end
    prev_read = (bus_read === 1'b1);
    prev_take = (bus_read === 1'b1) && (bus_acknowledge === 1'b1);
  end

  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic pulse_start(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] n);
    start = 1'b1; start_addr = a; word_count = n;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max);
    int base = done_cnt;
    int n = 0;
    while (done_cnt == base && n < max) begin
      tick();
      n++;
    end
    check_eq(tag, 32'(done_cnt - base), 32'd1);
  endtask

  logic [ADDR_W-1:0] exp_a [4] = '{26'h100, 26'h102, 26'h104, 26'h106};
  logic [15:0]       exp_d [4] = '{16'h5A80, 16'h5A81, 16'h5A82, 16'h5A83};

  initial begin
    int base_reads, base_done, base_err, base_busy, n, errs;
    reset_reset = 1'b1; start = 1'b0; start_addr = '0; word_count = '0;
    abort = 1'b0; out_ready = 1'b0; bus_acknowledge = 1'b0; bus_read_data = '0;
    repeat (3) tick();
    reset_reset = 1'b0;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_bus_read", bus_read, 0);
    check_eq("rst_byte_en", bus_byte_enable, 2'b11);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_done_error", {done, error}, 0);
    check_eq("rst_bus_write", {bus_write, bus_write_data}, 0);
    check_eq("rst_bus_address", bus_address, 0);
    tick();

    // Basic stream
    out_ready = 1'b1; ack_delay = 3;
    addr_q.delete(); data_q.delete();
    base_done = done_cnt;
    pulse_start(26'h100, 26'd4);
    check_eq("basic_busy_c1", busy, 1);
    check_eq("basic_read_c1", bus_read, 1);
    check_eq("basic_addr_c1", bus_address, 26'h100);
    wait_done("basic_done", 200);
    check_eq("basic_nreads", addr_q.size(), 4);
    check_eq("basic_nwords", data_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("basic_addr%0d", i), addr_q[i], exp_a[i]);
      check_eq($sformatf("basic_data%0d", i), data_q[i], exp_d[i]);
    end
    check_eq("basic_no_b2b", b2b_err, 0);
    check_eq("basic_busy_end", busy, 0);
    tick();
    check_eq("basic_done_pulse", done, 0);
    check_eq("basic_done_count", 32'(done_cnt - base_done), 1);

    // Backpressure
    out_ready = 1'b0; ack_delay = 1; data_q.delete();
    base_reads = reads_issued;
    pulse_start(26'h200, 26'd40);
    repeat (120) tick();
    check_eq("bp_reads_full", 32'(reads_issued - base_reads), 16);
    check_eq("bp_read_idle", bus_read, 0);
    check_eq("bp_head_valid", out_valid, 1);
    check_eq("bp_head_data", out_data, 16'h5B00);
    out_ready = 1'b1;
    wait_done("bp_done", 600);
    check_eq("bp_nwords", data_q.size(), 40);
    errs = 0;
    for (int i = 0; i < 40; i++)
      if (data_q[i] !== data_for(26'h200 + 26'(2 * i))) errs++;
    check_eq("bp_order", errs, 0);
    check_eq("bp_reads_total", 32'(reads_issued - base_reads), 40);
    check_eq("bp_no_b2b", b2b_err, 0);

    // Zero length
    tick();
    base_reads = reads_issued; base_busy = busy_cyc;
    pulse_start(26'h600, 26'd0);
    check_eq("zero_done", done, 1);
    check_eq("zero_busy", busy, 0);
    tick();
    check_eq("zero_done_pulse", done, 0);
    check_eq("zero_no_reads", 32'(reads_issued - base_reads), 0);
    check_eq("zero_no_busy", 32'(busy_cyc - base_busy), 0);

    // Timeout
    bridge_on = 1'b0; base_err = error_cnt;
    pulse_start(26'h300, 26'd2);
    n = 0;
    while (!error && n < 1100) begin
      tick();
      n++;
    end
    check_eq("to_error", error, 1);
    check_eq("to_latency", n, 1024);
    check_eq("to_busy", busy, 0);
    check_eq("to_read_low", bus_read, 0);
    check_eq("to_out_valid", out_valid, 0);
    tick();
    check_eq("to_read_cycles", last_run, 1024);
    check_eq("to_error_pulse", error, 0);
    check_eq("to_error_count", 32'(error_cnt - base_err), 1);
    bridge_on = 1'b1;

    // Abort mid-read
    ack_delay = 7; out_ready = 1'b1; data_q.delete();
    base_done = done_cnt; base_reads = reads_issued;
    pulse_start(26'h400, 26'd3);
    n = 0;
    while (!(bus_read && bus_address == 26'h402) && n < 100) begin
      tick();
      n++;
    end
    check_eq("ab_second_read", {bus_read, bus_address}, {1'b1, 26'h402});
    repeat (2) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("ab_read_held", bus_read, 1);
    n = 0;
    while (busy && n < 30) begin
      tick();
      n++;
    end
    check_eq("ab_idle", busy, 0);
    check_eq("ab_read_low", bus_read, 0);
    check_eq("ab_fifo_empty", out_valid, 0);
    tick();
    check_eq("ab_read_cycles", last_run, 8);
    check_eq("ab_no_done", 32'(done_cnt - base_done), 0);
    check_eq("ab_nwords", data_q.size(), 1);
    check_eq("ab_word0", data_q[0], 16'h5800);
    ack_delay = 2;
    pulse_start(26'h5000, 26'd1);
    wait_done("ab_restart_done", 50);
    check_eq("ab_restart_nwords", data_q.size(), 2);
    check_eq("ab_restart_word", data_q[1], 16'h7200);

    // Address wrap and reset mid-read
    ack_delay = 3; addr_q.delete(); data_q.delete();
    pulse_start(26'h3FFFFFE, 26'd2);
    check_eq("wrap_addr0", bus_address, 26'h3FFFFFE);
    n = 0;
    while (!(bus_read && bus_address == 26'h0) && n < 50) begin
      tick();
      n++;
    end
    check_eq("wrap_addr1", {bus_read, bus_address}, {1'b1, 26'h0});
    check_eq("wrap_first_logged", addr_q[0], 26'h3FFFFFE);
    check_eq("wrap_word0", data_q[0], 16'hA5FF);
    reset_reset = 1'b1;
    tick();
    check_eq("mid_rst_read", bus_read, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_addr", bus_address, 0);
    check_eq("mid_rst_valid", out_valid, 0);
    check_eq("mid_rst_done_error", {done, error}, 0);
    check_eq("mid_rst_byte_en", bus_byte_enable, 2'b11);
    reset_reset = 1'b0;
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sdram_stream_reader.md
# sdram_stream_reader

Bus initiator that drives the external-interface side of the SDRAM bridge, streaming a contiguous block of 16-bit words out of SDRAM into a small FIFO. A valid/ready output feeds the downstream audio decoder. It sits between the SDRAM subsystem's bridge port and the MP3 decode pipeline. It issues one read at a time and throttles on FIFO space.

## Interface
Parameters:
- ADDR_W, 26, byte-address width of the bridge
- FIFO_DEPTH, 16, output FIFO entries; power of two, at least 4
- TIMEOUT_CYCLES, 1024, cycles a read may wait for acknowledge before it is abandoned

Ports:
- clk_clk  in  1  single system clock; all logic is rising-edge
- reset_reset  in  1  synchronous reset, active-high
- start  in  1  one-cycle pulse; latches start_addr and word_count when idle
- start_addr  in  ADDR_W  byte address of the first word; bit 0 is ignored and forced to 0
- word_count  in  ADDR_W  number of 16-bit words to fetch
- abort  in  1  level or pulse; cancels the transfer in progress
- busy  out  1  high from the cycle after start is accepted until return to IDLE
- done  out  1  one-cycle pulse when every word has been consumed downstream
- error  out  1  one-cycle pulse on acknowledge timeout
- bus_address  out  ADDR_W  bridge address
- bus_byte_enable  out  2  constant 2'b11
- bus_read  out  1  read request
- bus_write  out  1  constant 0
- bus_write_data  out  16  constant 0
- bus_acknowledge  in  1  bridge completion strobe
- bus_read_data  in  16  valid in the cycle bus_acknowledge=1
- out_data  out  16  stream data
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts when out_valid and out_ready are both high

## Operation
- FSM states and transitions:
  - IDLE: start accepted → latch address and count, go to ISSUE. If word_count=0 → done pulse next cycle, stay IDLE, no bus activity. start is ignored when not in IDLE.
  - ISSUE: entered only when FIFO occupancy < FIFO_DEPTH. Drives bus_read=1 with bus_address; both are held stable until acknowledge.
  - On bus_acknowledge=1 in ISSUE: push bus_read_data into the FIFO, address += 2 (mod 2^ADDR_W, wraps silently), remaining −= 1. Then go to GAP, or to DRAIN if remaining becomes 0.
  - GAP: bus_read=0 for at least one cycle. Go to ISSUE when FIFO occupancy < FIFO_DEPTH; otherwise wait here.
  - DRAIN: no bus activity. When the FIFO is empty → done pulse, go to IDLE.
- At most one outstanding read. bus_read is never asserted in the same cycle an acknowledge is taken.
- Abort:
  - Sampled in any non-IDLE state.
  - In ISSUE, bus_read stays high until acknowledge or timeout, because the bridge transaction cannot be withdrawn. The returned data is discarded.
  - The FIFO is then flushed and the FSM returns to IDLE. No done pulse.
- Timeout: a 10+ bit counter runs while in ISSUE. On reaching TIMEOUT_CYCLES without acknowledge → drop bus_read, error pulse, flush FIFO, go to IDLE.
- FIFO: registered, first-word-fall-through.
  - Push and pop in the same cycle when full is legal; occupancy is unchanged.
  - A push is never attempted when full, because issue is gated on space.
- Reset: all outputs 0 except bus_byte_enable=2'b11. FSM to IDLE, FIFO empty, counters 0. Reset mid-transfer abandons the bus read immediately.

## Timing
- start sampled at cycle 0 → busy=1 and bus_read=1 at cycle 1.
- Acknowledge at cycle N:
  - data at FIFO head with out_valid=1 at cycle N+1
  - bus_read=0 at N+1 (GAP)
  - next bus_read at N+2 at the earliest
- Peak throughput is one word per (ack latency + 2) cycles.
- done is asserted the cycle after the pop that empties the FIFO in DRAIN; busy falls in the same cycle.
- error is asserted the cycle after the counter reaches TIMEOUT_CYCLES; bus_read falls in the same cycle.
- out_data and out_valid hold while out_valid=1 and out_ready=0.

## Test plan
- Basic stream:
  - Stimulus: start_addr=0x0000100, word_count=4, bridge acks 3 cycles after each read, out_ready=1.
  - Response: addresses 0x100, 0x102, 0x104, 0x106; 4 words out in order; one done pulse; no back-to-back bus_read.
- Backpressure:
  - Stimulus: word_count=40, FIFO_DEPTH=16, out_ready=0.
  - Response: exactly 16 reads issued and bus_read then stays 0. Raising out_ready drains all 40 words in order, then done.
- Zero length:
  - Stimulus: word_count=0.
  - Response: done one cycle after start; bus_read never asserted; busy stays 0.
- Timeout:
  - Stimulus: bridge never acks, TIMEOUT_CYCLES=1024.
  - Response: bus_read high exactly 1024 cycles; error pulse; busy=0; out_valid=0.
- Abort mid-read:
  - Stimulus: abort while bus_read=1, ack arrives 5 cycles later.
  - Response: bus_read held until the ack; data discarded; FIFO empty; no done. A new start is then accepted normally.
- Address wrap and reset:
  - Stimulus: start_addr=0x3FFFFFE, word_count=2.
  - Response: addresses 0x3FFFFFE then 0x0000000.
  - Stimulus: reset_reset during the second read.
  - Response: all outputs return to reset values the next cycle.
